jk_mod_counter: RTL and testbench

- Parametrised synchronous up/down modulo-N counter built from a bank of JK flip-flop cells.
- Each cell is driven by JK excitation logic derived from the next-state value.
- Successor to the single-bit JK flip-flop: generalised in width and modulus, adding load, direction, hold, terminal-count, wrap and load-error reporting.
- Used as a building block for dividers and sequencers.

---
 rtl/jk_mod_counter_pkg.sv | 18 +
 rtl/jk_mod_counter_cell.sv | 28 ++
 rtl/jk_mod_counter.sv | 106 ++++++++++
 tb/tb_jk_mod_counter.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/jk_mod_counter_pkg.sv
// Shared JK cell mode encodings and the excitation helper that maps
// a bit transition (cur -> nxt) onto the {j,k} pair for one cell.
package jk_mod_counter_pkg;

   localparam logic [1:0] JK_HOLD   = 2'b00;
   localparam logic [1:0] JK_RESET  = 2'b01;
   localparam logic [1:0] JK_SET    = 2'b10;
   localparam logic [1:0] JK_TOGGLE = 2'b11;

   // Never returns JK_TOGGLE: a bit that must change is always forced explicitly.
   function automatic logic [1:0] jk_excite(input logic cur, input logic nxt);
      logic [1:0] jk;
      jk[1] = nxt & ~cur;
      jk[0] = ~nxt & cur;
      return jk;
   endfunction

endpackage

// File: rtl/jk_mod_counter_cell.sv
// Single JK flip-flop with synchronous active-high reset to RST_VAL.
module jk_cell
   import jk_mod_counter_pkg::*;
#(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic j,
   input  logic k,
   output logic q
);

   always_ff @(posedge clk) begin
      if (reset) begin
         q <= RST_VAL;
      end else begin
         case ({j, k})
            JK_HOLD:   q <= q;
            JK_RESET:  q <= 1'b0;
            JK_SET:    q <= 1'b1;
            JK_TOGGLE: q <= ~q;
            default:   q <= q;
         endcase
      end
   end

endmodule

// File: rtl/jk_mod_counter.sv
// Up/down modulo-MODULUS counter whose state bits are JK cells driven
// from the selected next value; also produces tc, wrap and load_err.
module jk_mod_counter
   import jk_mod_counter_pkg::*;
#(
   parameter int WIDTH     = 4,
   parameter int MODULUS   = 10,
   parameter int RESET_VAL = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] q,
   output logic             tc,
   output logic             wrap,
   output logic             load_err
);

   if (MODULUS < 2 || MODULUS > (2 ** WIDTH) || RESET_VAL >= MODULUS || RESET_VAL < 0) begin : g_bad_params
      $error("jk_mod_counter: illegal WIDTH/MODULUS/RESET_VAL combination");
   end

   // Compare in WIDTH+1 bits so MODULUS = 2**WIDTH is representable.
   localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);
   localparam logic [WIDTH:0]   MOD_M1  = (WIDTH+1)'(MODULUS - 1);
   localparam logic [WIDTH-1:0] RST_Q   = WIDTH'(RESET_VAL);

   logic [WIDTH:0]   q_ext;
   logic [WIDTH:0]   sum_ext;
   logic [WIDTH-1:0] nxt;
   logic [WIDTH-1:0] jv;
   logic [WIDTH-1:0] kv;
   logic             wrap_d;
   logic             err_d;

   assign q_ext = {1'b0, q};

   always_comb begin
      nxt     = q;
      wrap_d  = 1'b0;
      err_d   = 1'b0;
      sum_ext = '0;
      if (load) begin
         if ({1'b0, load_val} < MOD_EXT) begin
            nxt = load_val;
         end else begin
            nxt   = MOD_M1[WIDTH-1:0];
            err_d = 1'b1;
         end
      end else if (en) begin
         if (up) begin
            if (q_ext == MOD_M1) begin
               nxt    = '0;
               wrap_d = 1'b1;
            end else begin
               sum_ext = q_ext + 1'b1;
               nxt     = sum_ext[WIDTH-1:0];
            end
         end else begin
            if (q_ext == '0) begin
               nxt    = MOD_M1[WIDTH-1:0];
               wrap_d = 1'b1;
            end else begin
               sum_ext = q_ext - 1'b1;
               nxt     = sum_ext[WIDTH-1:0];
            end
         end
      end
   end

   always_comb begin
      jv = '0;
      kv = '0;
      for (int i = 0; i < WIDTH; i++) begin
         {jv[i], kv[i]} = jk_excite(q[i], nxt[i]);
      end
   end

   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
      jk_cell #(
         .RST_VAL (RST_Q[gi])
      ) u_cell (
         .clk   (clk),
         .reset (reset),
         .j     (jv[gi]),
         .k     (kv[gi]),
         .q     (q[gi])
      );
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wrap     <= 1'b0;
         load_err <= 1'b0;
      end else begin
         wrap     <= wrap_d;
         load_err <= err_d;
      end
   end

   assign tc = up ? (q_ext == MOD_M1) : (q_ext == '0);

endmodule

// File: tb/tb_jk_mod_counter.sv
// Directed and model-checked stimulus for a mod-10 instance and a
// 3-bit mod-8 instance with non-zero reset value.
module tb_jk_mod_counter;

   logic       clk = 1'b0;
   logic       reset, en, up, load;
   logic [3:0] load_val;
   logic [3:0] q;
   logic       tc, wrap, load_err;

   logic       reset8, en8, up8, load8;
   logic [2:0] load_val8;
   logic [2:0] q8;
   logic       tc8, wrap8, load_err8;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   jk_mod_counter #(.WIDTH(4), .MODULUS(10), .RESET_VAL(0)) dut (
      .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
      .load_val(load_val), .q(q), .tc(tc), .wrap(wrap), .load_err(load_err)
   );

   jk_mod_counter #(.WIDTH(3), .MODULUS(8), .RESET_VAL(6)) dut8 (
      .clk(clk), .reset(reset8), .en(en8), .up(up8), .load(load8),
      .load_val(load_val8), .q(q8), .tc(tc8), .wrap(wrap8), .load_err(load_err8)
   );

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk10(input string tag, input int eq, input int etc, input int ew, input int ee);
      chk({tag, ".q"}, int'(q), eq);
      chk({tag, ".tc"}, int'(tc), etc);
      chk({tag, ".wrap"}, int'(wrap), ew);
      chk({tag, ".load_err"}, int'(load_err), ee);
   endtask

   int mq, mw, me;
   logic r_rst, r_en, r_up, r_ld;
   logic [3:0] r_lv;

   initial begin
      reset = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; load_val = 4'd0;
      reset8 = 1'b1; en8 = 1'b0; up8 = 1'b1; load8 = 1'b0; load_val8 = 3'd0;
      tick();
      chk10("reset", 0, 0, 0, 0);

      // Count up through the wrap.
      reset = 1'b0; en = 1'b1; up = 1'b1;
      for (int i = 1; i <= 12; i++) begin
         tick();
         chk10($sformatf("up%0d", i), i % 10, ((i % 10) == 9) ? 1 : 0, (i == 10) ? 1 : 0, 0);
      end

      // Load 7 then count down through the wrap.
      load = 1'b1; load_val = 4'd7; en = 1'b0; up = 1'b0;
      tick();
      chk10("ld7", 7, 0, 0, 0);
      load = 1'b0; en = 1'b1;
      for (int i = 1; i <= 9; i++) begin
         tick();
         chk10($sformatf("dn%0d", i), (17 - i) % 10, (i == 7) ? 1 : 0, (i == 8) ? 1 : 0, 0);
      end

      // Clipped and boundary loads, with en held high to show it is ignored.
      up = 1'b1;
      load = 1'b1; load_val = 4'd12;
      tick(); chk10("ld12", 9, 1, 0, 1);
      load_val = 4'd3;
      tick(); chk10("ld3", 3, 0, 0, 0);
      load_val = 4'd10;
      tick(); chk10("ld10", 9, 1, 0, 1);
      load = 1'b0; en = 1'b0;
      tick(); chk10("hold_after_err", 9, 1, 0, 0);
      load = 1'b1; load_val = 4'd9;
      tick(); chk10("ld9", 9, 1, 0, 0);

      // Reset beats load and en on the same edge, even from q=9 counting up.
      load = 1'b0; en = 1'b1; load_val = 4'd15;
      reset = 1'b1; load = 1'b1;
      tick(); chk10("rst_wins", 0, 0, 0, 0);
      reset = 1'b0; load = 1'b1; load_val = 4'd5; en = 1'b0;
      tick(); chk10("ld5", 5, 0, 0, 0);
      reset = 1'b1; load = 1'b1; load_val = 4'd14; en = 1'b1;
      tick(); chk10("rst_wins2", 0, 0, 0, 0);

      // Hold with up toggling: tc follows up combinationally at q=0.
      reset = 1'b0; load = 1'b0; en = 1'b0;
      for (int i = 0; i < 5; i++) begin
         up = i[0];
         #1;
         chk("tc_comb", int'(tc), (i[0] == 1'b1) ? 0 : 1);
         tick();
         chk10($sformatf("hold%0d", i), 0, (i[0] == 1'b1) ? 0 : 1, 0, 0);
      end

      // Power-of-two modulus, reset value 6.
      chk("m8.rst_q", int'(q8), 6);
      reset8 = 1'b0; en8 = 1'b1; up8 = 1'b1;
      #1; chk("m8.tc6", int'(tc8), 0);
      tick(); chk("m8.q7", int'(q8), 7); chk("m8.tc7", int'(tc8), 1); chk("m8.w7", int'(wrap8), 0);
      tick(); chk("m8.q0", int'(q8), 0); chk("m8.w0", int'(wrap8), 1);
      tick(); chk("m8.q1", int'(q8), 1); chk("m8.w1", int'(wrap8), 0);
      up8 = 1'b0;
      tick(); chk("m8.dq0", int'(q8), 0); chk("m8.dtc", int'(tc8), 1);
      tick(); chk("m8.dq7", int'(q8), 7); chk("m8.dw", int'(wrap8), 1);
      load8 = 1'b1;
      for (int v = 0; v < 8; v++) begin
         load_val8 = 3'(v);
         tick();
         chk("m8.ld_q", int'(q8), v);
         chk("m8.ld_err", int'(load_err8), 0);
      end
      load8 = 1'b0; en8 = 1'b0;

      // Reference-model run with random controls.
      mq = 0; mw = 0; me = 0;
      for (int c = 0; c < 3000; c++) begin
         r_rst = ($urandom_range(0, 63) == 0);
         r_ld  = ($urandom_range(0, 7) == 0);
         r_en  = 1'($urandom_range(0, 1));
         r_up  = 1'($urandom_range(0, 1));
         r_lv  = 4'($urandom_range(0, 15));
         reset = r_rst; load = r_ld; en = r_en; up = r_up; load_val = r_lv;
         #1;
         chk("rnd.tc", int'(tc), r_up ? ((mq == 9) ? 1 : 0) : ((mq == 0) ? 1 : 0));
         chk("rnd.jk", int'(dut.jv & dut.kv), 0);
         if (r_rst) begin
            mq = 0; mw = 0; me = 0;
         end else if (r_ld) begin
            mw = 0;
            if (int'(r_lv) < 10) begin mq = int'(r_lv); me = 0; end
            else begin mq = 9; me = 1; end
         end else if (r_en) begin
            me = 0;
            if (r_up) begin
               if (mq == 9) begin mq = 0; mw = 1; end else begin mq = mq + 1; mw = 0; end
            end else begin
               if (mq == 0) begin mq = 9; mw = 1; end else begin mq = mq - 1; mw = 0; end
            end
         end else begin
            mw = 0; me = 0;
         end
         tick();
         chk("rnd.q", int'(q), mq);
         chk("rnd.wrap", int'(wrap), mw);
         chk("rnd.load_err", int'(load_err), me);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
